colour_palette_conv: RTL and testbench
======================================

# colour_palette_conv

Parametrised, pipelined colour-index-to-RGB converter with a run-time writable palette and per-pixel brightness scaling. It supersedes the fixed 8-entry combinational colour converter. It sits between pattern/state logic that produces colour indices and the LED/display driver that consumes packed RGB. Output arrives a fixed 2 cycles after a qualified request, with a `valid` strobe.

## Interface
Parameters:
- `IDX_W`, default 3: colour index width. The palette has 2^IDX_W entries.
- `CH_W`, default 8: bits per colour channel. Legal range is 4..16.
- `BR_W`, default 4: brightness input width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: qualifies a lookup request this cycle.
- `colour`, input, IDX_W: palette index to convert.
- `brightness`, input, BR_W: scale factor, sampled together with `colour`.
- `wr_en`, input, 1: palette write strobe.
- `wr_addr`, input, IDX_W: palette entry to write.
- `wr_data`, input, 3*CH_W: new entry, packed {R,G,B}, R in the MSBs.
- `rgb`, output, 3*CH_W: converted colour, packed {R,G,B}.
- `valid`, output, 1: `rgb` holds the result of a request issued 2 cycles earlier.

## Operation
- **Palette storage:** 2^IDX_W registers of 3*CH_W bits each.
- **Palette reset contents:**
  - Index 0: FFFFFF (white).
  - Index 1: FF0000 (red).
  - Index 2: FFA500 (orange).
  - Index 3: 0000FF (blue).
  - Index 4: 00FF00 (green).
  - All other indices: 0.
  - Channel constants are 8-bit and MSB-aligned into CH_W. For CH_W<8, keep the top CH_W bits. For CH_W>8, pad the LSBs with zeros, except that FF maps to all-ones.
- **Write:** when `wr_en`=1, `palette[wr_addr]` <= `wr_data` at the clock edge. There is no backpressure and a write is never dropped.
- **Stage 1:** when `enable`=1, register `palette[colour]` into `s1_rgb` and `brightness` into `s1_br`. `s1_valid` <= `enable` every cycle.
- **Read/write collision:** a lookup and a write to the same index in the same cycle returns the OLD entry (read-before-write). The new entry is visible to requests from the next cycle on.
- **Stage 2:** when `s1_valid`=1, each channel out = (ch_in × (s1_br+1)) >> BR_W. `valid` <= `s1_valid` every cycle.
- **Scaling arithmetic:**
  - The product is computed at CH_W+BR_W+1 bits.
  - The result is floored and fits CH_W; no saturation logic is needed.
  - `brightness` = all-ones is the identity.
  - `brightness` = 0 gives ch_in >> BR_W, not black.
- **Hold behaviour:** `rgb` holds its last value while `valid`=0. Stage registers are not updated when their qualifier is low.
- **Back-to-back requests:** fully pipelined. One result is produced per cycle with no bubbles.

## Timing
- **Reset values:** `rgb`=0 and `valid`=0. All stage registers are 0. The palette is loaded with its reset contents.
- **Latency:** request at edge N (`enable`=1 sampled) gives `valid`=1 and `rgb` valid after edge N+2.
- **Reset asserted mid-stream:** all in-flight requests are discarded and `valid` drops immediately (asynchronously). Writes made before reset are lost.
- **Reset release:** the first request accepted is at the first rising edge with `rst`=0.
- **`wr_en` during reset:** ignored.

## Configuration
- Macro `COLOUR_PALETTE_DIM_EN` defined: stage 2 performs the brightness multiply described above.
- Macro undefined:
  - Stage 2 is a pure register: `rgb` <= `s1_rgb`.
  - The `brightness` port is present but ignored, and no multiplier is synthesised.
  - Latency stays 2 cycles and `valid` timing is unchanged.

## Test plan
Defaults (IDX_W=3, CH_W=8, BR_W=4) with the macro defined, unless stated otherwise.
1. Reset, then `enable`=1 for colours 0..7 on consecutive cycles with `brightness`=F -> from 2 cycles later: FFFFFF, FF0000, FFA500, 0000FF, 00FF00, 000000, 000000, 000000, with `valid` high for exactly 8 cycles.
2. Colour 2 with `brightness`=7 -> `rgb`=7F5200. Colour 0 with `brightness`=0 -> `rgb`=0F0F0F.
3. `wr_en`=1, `wr_addr`=5, `wr_data`=123456, with a lookup of colour 5 in the same cycle -> that result is 000000. A lookup of colour 5 on the next cycle -> 123456.
4. `enable` pattern 1,0,1 -> `valid` pattern 1,0,1, delayed 2 cycles. `rgb` holds the first result during the gap.
5. Assert `rst` while 2 requests are in flight after writing palette[1]=ABCDEF -> `valid`=0 and `rgb`=0 immediately. After release, colour 1 returns FF0000.
6. Macro undefined: colour 1 with `brightness`=0 -> `rgb`=FF0000 after 2 cycles.

Source files
------------

// File: rtl/colour_palette_conv.sv
// Palette lookup with optional per-pixel brightness scaling, 2-stage pipeline.
// Define COLOUR_PALETTE_DIM_EN to build the brightness multiplier in stage 2.
module colour_palette_conv #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8,
  parameter int BR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [IDX_W-1:0]  colour,
  input  logic [BR_W-1:0]   brightness,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  output logic [3*CH_W-1:0] rgb,
  output logic              valid
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int RGB_W = 3 * CH_W;

  // 8-bit constants MSB-aligned; full-scale stays full-scale at any width
  function automatic logic [CH_W-1:0] ch_const(input logic [7:0] c);
    logic [CH_W+7:0] w;
    w = {c, {CH_W{1'b0}}};
    if (c == 8'hFF) return '1;
    return w[CH_W+7 -: CH_W];
  endfunction

  function automatic logic [RGB_W-1:0] rst_entry(input int idx);
    logic [RGB_W-1:0] e;
    case (idx)
      0: e = {ch_const(8'hFF), ch_const(8'hFF), ch_const(8'hFF)};
      1: e = {ch_const(8'hFF), ch_const(8'h00), ch_const(8'h00)};
      2: e = {ch_const(8'hFF), ch_const(8'hA5), ch_const(8'h00)};
      3: e = {ch_const(8'h00), ch_const(8'h00), ch_const(8'hFF)};
      4: e = {ch_const(8'h00), ch_const(8'hFF), ch_const(8'h00)};
      default: e = '0;
    endcase
    return e;
  endfunction

  logic [RGB_W-1:0] pal [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_pal
    localparam logic [RGB_W-1:0] RST_VAL = rst_entry(g);
    logic [RGB_W-1:0] ent_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ent_q <= RST_VAL;
      end else if (wr_en && (wr_addr == IDX_W'(g))) begin
        ent_q <= wr_data;
      end
    end

    assign pal[g] = ent_q;
  end

  logic             s1_valid_q;
  logic [RGB_W-1:0] s1_rgb_q;
  logic [RGB_W-1:0] scaled;

`ifdef COLOUR_PALETTE_DIM_EN
  localparam int PW = CH_W + BR_W + 1;

  logic [BR_W-1:0] s1_br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_br_q <= '0;
    end else if (enable) begin
      s1_br_q <= brightness;
    end
  end

  // out = ch * (br + 1) >> BR_W; full brightness is the identity
  for (genvar c = 0; c < 3; c++) begin : g_scale
    logic [PW-1:0] mult;
    logic [PW-1:0] prod;
    assign mult = PW'(s1_br_q) + PW'(1);
    assign prod = PW'(s1_rgb_q[c*CH_W +: CH_W]) * mult;
    assign scaled[c*CH_W +: CH_W] = CH_W'(prod >> BR_W);
  end
`else
  logic unused_br;
  assign unused_br = ^brightness;
  assign scaled    = s1_rgb_q;
`endif

  // Palette read sees pre-edge contents, so a same-cycle write is not bypassed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
      valid      <= 1'b0;
      rgb        <= '0;
    end else begin
      s1_valid_q <= enable;
      valid      <= s1_valid_q;
      if (enable) begin
        s1_rgb_q <= pal[colour];
      end
      if (s1_valid_q) begin
        rgb <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_colour_palette_conv.sv
// Directed checks for colour_palette_conv at default parameters.
// Expected brightness results follow COLOUR_PALETTE_DIM_EN.
module tb_colour_palette_conv;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  colour;
  logic [3:0]  brightness;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [23:0] rgb;
  logic        valid;

  int checks;
  int failures;

`ifdef COLOUR_PALETTE_DIM_EN
  localparam logic [23:0] EXP_C2_B7 = 24'h7F5200;
  localparam logic [23:0] EXP_C0_B0 = 24'h0F0F0F;
  localparam logic [23:0] EXP_C1_B0 = 24'h0F0000;
`else
  localparam logic [23:0] EXP_C2_B7 = 24'hFFA500;
  localparam logic [23:0] EXP_C0_B0 = 24'hFFFFFF;
  localparam logic [23:0] EXP_C1_B0 = 24'hFF0000;
`endif

  colour_palette_conv dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .colour     (colour),
    .brightness (brightness),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rgb        (rgb),
    .valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    colour = '0;
    brightness = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %b exp 0", valid);
    end
    checks++;
    if (rgb !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got %h exp 000000", rgb);
    end
    rst = 1'b0;
  endtask

  task automatic test_palette_sweep();
    logic [23:0] exp_tab [8];
    int nvalid;
    int idx;
    exp_tab[0] = 24'hFFFFFF;
    exp_tab[1] = 24'hFF0000;
    exp_tab[2] = 24'hFFA500;
    exp_tab[3] = 24'h0000FF;
    exp_tab[4] = 24'h00FF00;
    exp_tab[5] = 24'h000000;
    exp_tab[6] = 24'h000000;
    exp_tab[7] = 24'h000000;
    nvalid = 0;
    brightness = 4'hF;
    for (int k = 0; k < 12; k++) begin
      enable = (k < 8);
      colour = 3'(k);
      tick();
      idx = k - 1;
      if (valid === 1'b1) nvalid++;
      checks++;
      if (valid !== ((idx >= 0) && (idx < 8))) begin
        failures++;
        $display("FAIL sweep_valid cyc %0d got %b", k, valid);
      end
      if ((idx >= 0) && (idx < 8)) begin
        checks++;
        if (rgb !== exp_tab[idx]) begin
          failures++;
          $display("FAIL sweep_rgb idx %0d got %h exp %h",
                   idx, rgb, exp_tab[idx]);
        end
      end
    end
    checks++;
    if (nvalid != 8) begin
      failures++;
      $display("FAIL sweep_count got %0d exp 8", nvalid);
    end
  endtask

  task automatic test_brightness();
    enable = 1'b1;
    colour = 3'd2;
    brightness = 4'd7;
    tick();
    colour = 3'd0;
    brightness = 4'd0;
    tick();
    enable = 1'b0;
    checks++;
    if (valid !== 1'b1 || rgb !== EXP_C2_B7) begin
      failures++;
      $display("FAIL bright_c2_b7 got %b/%h exp 1/%h", valid, rgb, EXP_C2_B7);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== EXP_C0_B0) begin
      failures++;
      $display("FAIL bright_c0_b0 got %b/%h exp 1/%h", valid, rgb, EXP_C0_B0);
    end
    tick();
  endtask

  task automatic test_collision();
    brightness = 4'hF;
    enable = 1'b1;
    colour = 3'd5;
    wr_en = 1'b1;
    wr_addr = 3'd5;
    wr_data = 24'h123456;
    tick();
    wr_en = 1'b0;
    tick();
    enable = 1'b0;
    checks++;
    if (valid !== 1'b1 || rgb !== 24'h000000) begin
      failures++;
      $display("FAIL collide_old got %b/%h exp 1/000000", valid, rgb);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== 24'h123456) begin
      failures++;
      $display("FAIL collide_new got %b/%h exp 1/123456", valid, rgb);
    end
    tick();
  endtask

  task automatic test_gap();
    brightness = 4'hF;
    enable = 1'b1;
    colour = 3'd3;
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== 24'h0000FF) begin
      failures++;
      $display("FAIL gap_first got %b/%h exp 1/0000ff", valid, rgb);
    end
    enable = 1'b1;
    colour = 3'd4;
    tick();
    enable = 1'b0;
    checks++;
    if (valid !== 1'b0 || rgb !== 24'h0000FF) begin
      failures++;
      $display("FAIL gap_hold got %b/%h exp 0/0000ff", valid, rgb);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== 24'h00FF00) begin
      failures++;
      $display("FAIL gap_second got %b/%h exp 1/00ff00", valid, rgb);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    brightness = 4'hF;
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_data = 24'hABCDEF;
    tick();
    wr_en = 1'b0;
    enable = 1'b1;
    colour = 3'd1;
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== 24'hABCDEF) begin
      failures++;
      $display("FAIL mid_written got %b/%h exp 1/abcdef", valid, rgb);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || rgb !== 24'h0) begin
      failures++;
      $display("FAIL mid_async got %b/%h exp 0/000000", valid, rgb);
    end
    enable = 1'b0;
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_data = 24'h123456;
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold got %b exp 0", valid);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    enable = 1'b1;
    colour = 3'd1;
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== 24'hFF0000) begin
      failures++;
      $display("FAIL mid_restored got %b/%h exp 1/ff0000", valid, rgb);
    end
    tick();
  endtask

  task automatic test_dim_off();
    enable = 1'b1;
    colour = 3'd1;
    brightness = 4'd0;
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || rgb !== EXP_C1_B0) begin
      failures++;
      $display("FAIL c1_b0 got %b/%h exp 1/%h", valid, rgb, EXP_C1_B0);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_palette_sweep();
    test_brightness();
    test_collision();
    test_gap();
    test_reset_midstream();
    test_dim_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
